// File: rtl/mem_port_arbiter_pkg.sv
// Shared width, FSM state and grant-source encodings for mem_port_arbiter.
// `WORD_WIDTH sets the default address/data width (32 unless predefined).
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package mem_port_arbiter_pkg;

    localparam int unsigned WORD_W = `WORD_WIDTH;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_FETCH = 2'd1;
    localparam logic [1:0] ARB_DATA  = 2'd2;
    localparam logic [1:0] ARB_RESP  = 2'd3;

    localparam logic [1:0] GNT_NONE  = 2'd0;
    localparam logic [1:0] GNT_FETCH = 2'd1;
    localparam logic [1:0] GNT_DATA  = 2'd2;

    // Data first, except a waiting fetch beats a second consecutive data grant.
    function automatic logic [1:0] arb_pick(input logic data_pend,
                                            input logic fetch_req,
                                            input logic last_data);
        if (data_pend && (!fetch_req || !last_data))
            return GNT_DATA;
        else if (fetch_req)
            return GNT_FETCH;
        else
            return GNT_NONE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Ack watchdog for mem_port_arbiter; only instantiated when MEM_TIMEOUT_EN is defined.
// expired is raised on the TIMEOUT-th consecutive waiting cycle.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (run)
            cnt <= cnt + CW'(1);
    end

    assign expired = run && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Define MEM_TIMEOUT_EN to add the ack watchdog and sticky mem_err flag.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned W       = `WORD_WIDTH,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_req,
    input  logic [W-1:0] if_addr,
    output logic [W-1:0] if_rdata,
    output logic         if_valid,
    input  logic         load_en,
    input  logic         store_en,
    input  logic [W-1:0] d_addr,
    input  logic [W-1:0] s_data,
    output logic [W-1:0] l_data,
    output logic         d_valid,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic         mem_err
);

    logic [1:0]   state;
    logic         last_data;
    logic [1:0]   pick;
    logic         data_pend;
    logic         timeout;
    logic [W-1:0] resp_data;

    assign data_pend = load_en | store_en;
    assign pick      = arb_pick(data_pend, if_req, last_data);
    assign resp_data = mem_ack ? mem_rdata : '0;
    assign stall     = (if_req & ~if_valid) | (data_pend & ~d_valid);

`ifdef MEM_TIMEOUT_EN
    logic wd_expired;
    logic wd_clear;
    logic wd_run;

    assign wd_clear = (state == ARB_IDLE) && (pick != GNT_NONE);
    assign wd_run   = (state == ARB_FETCH) || (state == ARB_DATA);

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .run     (wd_run),
        .expired (wd_expired)
    );

    // An ack arriving on the expiry cycle completes normally.
    assign timeout = wd_expired & ~mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem_err <= 1'b0;
        else if (timeout)
            mem_err <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            last_data <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            l_data    <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick == GNT_DATA) begin
                        state     <= ARB_DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= store_en;
                        mem_addr  <= d_addr;
                        mem_wdata <= s_data;
                        last_data <= 1'b1;
                    end else if (pick == GNT_FETCH) begin
                        state     <= ARB_FETCH;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        last_data <= 1'b0;
                    end
                end
                ARB_FETCH: begin
                    if (mem_ack || timeout) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        if_rdata <= resp_data;
                        if_valid <= 1'b1;
                        state    <= ARB_RESP;
                    end
                end
                ARB_DATA: begin
                    if (mem_ack || timeout) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_we)
                            l_data <= resp_data;
                        d_valid <= 1'b1;
                        state   <= ARB_RESP;
                    end
                end
                default: begin
                    if_valid <= 1'b0;
                    d_valid  <= 1'b0;
                    state    <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the CPU's instruction-fetch path (pc/inst) and its data path (load/store).
- Sequences one memory transaction at a time through a small FSM.
- Returns read data to the requester that issued it.
- Drives a `stall` output to the pc unit while any requester waits.
- Sits between the cpu core and the memory model/bus. It replaces the core's separate inst and l_data/s_data connections.

Parameters:
- W, `WORD_WIDTH (32): address and data width.
- TIMEOUT, 255: ack watchdog limit in cycles. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  W  fetch address (pc)
- if_rdata  out  W  fetched instruction
- if_valid  out  1  one-cycle pulse; if_rdata valid
- load_en  in  1  data load request; held until d_valid
- store_en  in  1  data store request; held until d_valid
- d_addr  in  W  load/store address
- s_data  in  W  store data
- l_data  out  W  load result
- d_valid  out  1  one-cycle pulse; load/store complete
- stall  out  1  pc hold
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  W  memory address
- mem_wdata  out  W  memory write data
- mem_rdata  in  W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- mem_err  out  1  sticky timeout flag; constant 0 without MEM_TIMEOUT_EN

Behaviour:
- Reset (async, immediate) drives:
  - state = IDLE
  - mem_req, mem_we, if_valid, d_valid, mem_err = 0
  - mem_addr, mem_wdata, if_rdata, l_data = 0
  - last_data = 0
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE:
  - data pending = load_en | store_en.
  - If data pending and (!if_req | !last_data): grant DATA.
  - Else if if_req: grant FETCH.
  - Else stay in IDLE.
  - Data has priority. After one data grant, a pending fetch wins the next arbitration (no starvation).
- On grant (registered):
  - mem_req = 1; mem_addr = selected address.
  - DATA grant: mem_we = store_en, mem_wdata = s_data. Store wins if load_en and store_en are both high.
  - FETCH grant: mem_we = 0.
  - last_data = (grant == DATA).
- FETCH/DATA: outputs held stable until mem_ack. On mem_ack:
  - mem_req = 0, mem_we = 0.
  - Capture mem_rdata into if_rdata (FETCH) or l_data (DATA load only; a store leaves l_data unchanged).
  - Pulse the matching valid next cycle; go to RESP.
- RESP: one cycle with valid high, then IDLE. The requester drops or changes its request on the valid cycle. The arbiter re-samples requests only in IDLE.
- Latency:
  - Request seen in IDLE at cycle N → mem_req at N+1.
  - Ack at cycle M ≥ N+1 → valid at M+1.
  - Minimum 2 cycles request-to-valid; back-to-back transactions every 3 cycles.
- mem_ack outside FETCH/DATA is ignored.
- stall (combinational) = (if_req & !if_valid) | ((load_en|store_en) & !d_valid).
- Requests dropped while granted: the transaction still completes and the valid pulse is still issued (memory side never aborted).
- Reset mid-transaction: mem_req deasserts asynchronously; no valid pulse is produced.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - 8+-bit watchdog counter, cleared on grant, increments each cycle in FETCH/DATA.
  - On reaching TIMEOUT without mem_ack: drop mem_req, return rdata 0, pulse the matching valid, set mem_err. mem_err stays high until rst.
  - Ack and timeout in the same cycle: the ack wins.
- Undefined: no counter; FETCH/DATA wait indefinitely; mem_err tied 0.

Decomposition:
- Shared package/defines.v holds:
  - `WORD_WIDTH
  - the state encoding constants (ARB_IDLE, ARB_FETCH, ARB_DATA, ARB_RESP)
  - grant-source encoding constants
- One natural sub-module: mem_arb_watchdog (counter + compare). It is instantiated only under MEM_TIMEOUT_EN.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x100, mem acks 1 cycle after mem_req with 0x2402000A → mem_addr=0x100, mem_we=0; if_rdata=0x2402000A and if_valid at request+3; stall high until then.
2. Simultaneous: if_req=1 (0x104) and load_en=1 (0x2000) in the same cycle → first mem_addr=0x2000, l_data returns, d_valid; then fetch 0x104 served.
3. Store: store_en=1, d_addr=0x3000, s_data=0xDEADBEEF, ack after 4 cycles → mem_we=1, mem_wdata=0xDEADBEEF held stable 4 cycles; d_valid one cycle; l_data unchanged.
4. Fairness: load_en held continuously (re-asserted every transaction) with if_req held → grants alternate DATA, FETCH, DATA, FETCH.
5. Reset mid-DATA: assert rst while mem_req=1 → mem_req=0 in the same cycle; no d_valid after release; next transaction normal.
6. MEM_TIMEOUT_EN, TIMEOUT=8, no ack → after 8 cycles mem_req=0, if_valid with if_rdata=0, mem_err=1 and sticky; a late mem_ack is ignored.
